// File: rtl/l1d_write_buffer.sv
// L1D-to-L2 write buffer: coalesces writes, forwards buffered data to reads, and sends read misses to L2 ahead of queued writes.
// Forwarded read hits respond 1 cycle after accept. l1_ready_out drops while full, flushing, or while a read is outstanding.
module l1d_write_buffer #(
   parameter int PADDR_BITS = 22,
   parameter int DEPTH      = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_N_in,
   input  logic                  flush_in,
   output logic                  flush_done_out,
   input  logic                  l1_valid_in,
   output logic                  l1_ready_out,
   input  logic [PADDR_BITS-1:0] l1_addr_in,
   input  logic [63:0]           l1_value_in,
   input  logic                  l1_we_in,
   output logic                  l1_valid_out,
   input  logic                  l1_ready_in,
   output logic [PADDR_BITS-1:0] l1_addr_out,
   output logic [63:0]           l1_value_out,
   output logic                  lc_valid_out,
   input  logic                  lc_ready_in,
   output logic [PADDR_BITS-1:0] lc_addr_out,
   output logic [63:0]           lc_value_out,
   output logic                  lc_we_out,
   input  logic                  lc_valid_in,
   output logic                  lc_ready_out,
   input  logic [PADDR_BITS-1:0] lc_addr_in,
   input  logic [63:0]           lc_value_in
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR} state_e;

   state_e                  state_q, state_d;
   logic [PADDR_BITS-1:0]   ent_addr_q [DEPTH];
   logic [63:0]             ent_val_q  [DEPTH];
   logic [PW-1:0]           head_q, tail_q;
   logic [CW-1:0]           count_q, count_d;
   logic                    rd_busy_q, rd_pend_q;
   logic [PADDR_BITS-1:0]   rd_addr_q;
   logic                    resp_valid_q;
   logic [PADDR_BITS-1:0]   resp_addr_q;
   logic [63:0]             resp_val_q;

   logic                    l1_fire, wr_fire, rd_fire, enq, pop, lc_resp_fire, resp_take;
   logic                    hit, co_hit;
   logic [PW-1:0]           hit_idx, co_idx;

   // Gating with the reset pin keeps every output low while reset is held.
   assign l1_ready_out   = rst_N_in && !flush_in && !rd_busy_q && (count_q < CW'(DEPTH));
   assign flush_done_out = rst_N_in && flush_in && (count_q == '0) && (state_q == IDLE) && !rd_busy_q;
   assign l1_valid_out   = resp_valid_q;
   assign l1_addr_out    = resp_addr_q;
   assign l1_value_out   = resp_val_q;

   assign l1_fire      = l1_valid_in && l1_ready_out;
   assign wr_fire      = l1_fire && l1_we_in;
   assign rd_fire      = l1_fire && !l1_we_in;
   assign enq          = wr_fire && !co_hit;
   assign pop          = (state_q == ISSUE_WR) && lc_ready_in;
   assign lc_resp_fire = lc_valid_in && lc_ready_out;
   assign resp_take    = resp_valid_q && l1_ready_in;

   // Scan oldest to youngest so the last match wins; the head is excluded from
   // coalescing while it is on the L2 bus.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      co_hit  = 1'b0;
      co_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count_q) && (ent_addr_q[head_q + PW'(i)] == l1_addr_in)) begin
            hit     = 1'b1;
            hit_idx = head_q + PW'(i);
            if (!((state_q == ISSUE_WR) && (i == 0))) begin
               co_hit = 1'b1;
               co_idx = head_q + PW'(i);
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (enq && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!enq && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (rd_pend_q) begin
               state_d = ISSUE_RD;
            end else if (count_q != '0) begin
               state_d = ISSUE_WR;
            end
         end
         ISSUE_RD: if (lc_ready_in)  state_d = WAIT_RD;
         WAIT_RD:  if (lc_resp_fire) state_d = IDLE;
         ISSUE_WR: if (lc_ready_in)  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      lc_valid_out = 1'b0;
      lc_we_out    = 1'b0;
      lc_addr_out  = '0;
      lc_value_out = '0;
      lc_ready_out = 1'b0;
      case (state_q)
         ISSUE_RD: begin
            lc_valid_out = 1'b1;
            lc_addr_out  = rd_addr_q;
         end
         WAIT_RD: begin
            lc_ready_out = !resp_valid_q;
         end
         ISSUE_WR: begin
            lc_valid_out = 1'b1;
            lc_we_out    = 1'b1;
            lc_addr_out  = ent_addr_q[head_q];
            lc_value_out = ent_val_q[head_q];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_val_q[i]  <= '0;
         end
      end else begin
         if (wr_fire) begin
            if (co_hit) begin
               ent_val_q[co_idx] <= l1_value_in;
            end else begin
               ent_addr_q[tail_q] <= l1_addr_in;
               ent_val_q[tail_q]  <= l1_value_in;
               tail_q             <= tail_q + PW'(1);
            end
         end
         if (pop) begin
            head_q <= head_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_in or negedge rst_N_in) begin
      if (!rst_N_in) begin
         rd_busy_q    <= 1'b0;
         rd_pend_q    <= 1'b0;
         rd_addr_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_addr_q  <= '0;
         resp_val_q   <= '0;
      end else begin
         if (rd_fire) begin
            rd_busy_q <= 1'b1;
         end else if (resp_take) begin
            rd_busy_q <= 1'b0;
         end

         if (rd_fire && !hit) begin
            rd_pend_q <= 1'b1;
            rd_addr_q <= l1_addr_in;
         end else if ((state_q == ISSUE_RD) && lc_ready_in) begin
            rd_pend_q <= 1'b0;
         end

         if (rd_fire && hit) begin
            resp_valid_q <= 1'b1;
            resp_addr_q  <= l1_addr_in;
            resp_val_q   <= ent_val_q[hit_idx];
         end else if (lc_resp_fire) begin
            resp_valid_q <= 1'b1;
            resp_addr_q  <= lc_addr_in;
            resp_val_q   <= lc_value_in;
         end else if (resp_take) begin
            resp_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_l1d_write_buffer.sv
// Directed bench for l1d_write_buffer: table-driven fill/coalesce/drain plus forward, miss, flush and reset sequences.
module tb_l1d_write_buffer;

   logic        clk_in = 1'b0;
   logic        rst_N_in;
   logic        flush_in;
   logic        flush_done_out;
   logic        l1_valid_in;
   logic        l1_ready_out;
   logic [21:0] l1_addr_in;
   logic [63:0] l1_value_in;
   logic        l1_we_in;
   logic        l1_valid_out;
   logic        l1_ready_in;
   logic [21:0] l1_addr_out;
   logic [63:0] l1_value_out;
   logic        lc_valid_out;
   logic        lc_ready_in;
   logic [21:0] lc_addr_out;
   logic [63:0] lc_value_out;
   logic        lc_we_out;
   logic        lc_valid_in;
   logic        lc_ready_out;
   logic [21:0] lc_addr_in;
   logic [63:0] lc_value_in;

   l1d_write_buffer #(.PADDR_BITS(22), .DEPTH(4)) dut (
      .clk_in(clk_in), .rst_N_in(rst_N_in), .flush_in(flush_in), .flush_done_out(flush_done_out),
      .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out), .l1_addr_in(l1_addr_in),
      .l1_value_in(l1_value_in), .l1_we_in(l1_we_in), .l1_valid_out(l1_valid_out),
      .l1_ready_in(l1_ready_in), .l1_addr_out(l1_addr_out), .l1_value_out(l1_value_out),
      .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
      .lc_value_out(lc_value_out), .lc_we_out(lc_we_out), .lc_valid_in(lc_valid_in),
      .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        we;
      logic [21:0] addr;
      logic [63:0] val;
   } txn_t;

   typedef struct {
      logic [21:0] addr;
      logic [63:0] val;
      logic        exp_rdy;
      int          exp_cnt;
      int          ndrain;
   } vec_t;

   typedef struct {
      logic [21:0] addr;
      logic [63:0] val;
   } exp_t;

   txn_t log_q[$];
   int   rd_issue_seen = 0;
   int   total = 0;
   int   bad   = 0;

   // L2 bus monitor, sampled mid-low-phase once inputs have settled.
   always @(negedge clk_in) begin
      #2;
      if (rst_N_in && lc_valid_out && lc_ready_in) log_q.push_back('{lc_we_out, lc_addr_out, lc_value_out});
      if (rst_N_in && lc_valid_out && !lc_we_out) rd_issue_seen++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic req(input logic we, input logic [21:0] a, input logic [63:0] v);
      int t;
      @(negedge clk_in);
      l1_valid_in = 1'b1;
      l1_we_in    = we;
      l1_addr_in  = a;
      l1_value_in = v;
      #1;
      t = 0;
      while (!l1_ready_out && t < 100) begin
         @(negedge clk_in);
         #1;
         t++;
      end
      if (!l1_ready_out) chk($sformatf("req_accept_%0h", a), 64'(l1_ready_out), 64'd1);
      @(negedge clk_in);
      l1_valid_in = 1'b0;
      l1_we_in    = 1'b0;
   endtask

   task automatic wait_log(input int n, input string name);
      int t;
      t = 0;
      while (log_q.size() < n && t < 200) begin
         @(negedge clk_in);
         t++;
      end
      repeat (4) @(negedge clk_in);
      chk(name, 64'(log_q.size()), 64'(n));
   endtask

   task automatic chk_log(input int i, input logic we, input logic [21:0] a, input logic [63:0] v);
      if (i >= log_q.size()) begin
         chk($sformatf("log%0d_present", i), 64'(log_q.size()), 64'(i + 1));
      end else begin
         chk($sformatf("log%0d_we", i), 64'(log_q[i].we), 64'(we));
         chk($sformatf("log%0d_addr", i), 64'(log_q[i].addr), 64'(a));
         chk($sformatf("log%0d_val", i), log_q[i].val, v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vt[7];
      exp_t ed[6];
      int   dp;
      int   rd0;
      int   t;
      logic found;
      logic seen;

      vt[0] = '{22'h10, 64'hA0, 1'b1, 1, 0};
      vt[1] = '{22'h18, 64'hA1, 1'b1, 2, 0};
      vt[2] = '{22'h20, 64'hA2, 1'b1, 3, 0};
      vt[3] = '{22'h28, 64'hA3, 1'b0, 4, 4};
      vt[4] = '{22'h40, 64'h1,  1'b1, 1, 0};
      vt[5] = '{22'h48, 64'h2,  1'b1, 2, 0};
      vt[6] = '{22'h48, 64'h3,  1'b1, 2, 2};
      ed[0] = '{22'h10, 64'hA0};
      ed[1] = '{22'h18, 64'hA1};
      ed[2] = '{22'h20, 64'hA2};
      ed[3] = '{22'h28, 64'hA3};
      ed[4] = '{22'h40, 64'h1};
      ed[5] = '{22'h48, 64'h3};

      rst_N_in = 1'b0; flush_in = 1'b0;
      l1_valid_in = 1'b0; l1_addr_in = '0; l1_value_in = '0; l1_we_in = 1'b0; l1_ready_in = 1'b0;
      lc_ready_in = 1'b0; lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;

      #3;
      chk("reset_ctrl_outs", 64'({l1_ready_out, l1_valid_out, lc_valid_out, lc_we_out, lc_ready_out, flush_done_out}), 64'd0);
      chk("reset_data_outs", 64'({l1_addr_out, lc_addr_out}) | l1_value_out | lc_value_out, 64'd0);
      repeat (2) @(negedge clk_in);
      rst_N_in = 1'b1;
      #1;
      chk("post_reset_ready", 64'(l1_ready_out), 64'd1);

      // Fill/coalesce vectors with L2 stalled, then drain at each group end.
      dp = 0;
      for (int i = 0; i < 7; i++) begin
         req(1'b1, vt[i].addr, vt[i].val);
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(l1_ready_out), 64'(vt[i].exp_rdy));
         chk($sformatf("vec%0d_count", i), 64'(dut.count_q), 64'(vt[i].exp_cnt));
         if (vt[i].ndrain > 0) begin
            log_q.delete();
            lc_ready_in = 1'b1;
            wait_log(vt[i].ndrain, $sformatf("vec%0d_drain_count", i));
            lc_ready_in = 1'b0;
            for (int k = 0; k < vt[i].ndrain; k++) chk_log(k, 1'b1, ed[dp + k].addr, ed[dp + k].val);
            dp += vt[i].ndrain;
            #1;
            chk($sformatf("vec%0d_ready_after_drain", i), 64'(l1_ready_out), 64'd1);
         end
      end

      // Forward: read of a buffered address answers next cycle without touching L2.
      l1_ready_in = 1'b1;
      req(1'b1, 22'h80, 64'hDEAD);
      rd0 = rd_issue_seen;
      req(1'b0, 22'h80, 64'h0);
      #1;
      chk("fwd_valid", 64'(l1_valid_out), 64'd1);
      chk("fwd_value", l1_value_out, 64'hDEAD);
      chk("fwd_addr", 64'(l1_addr_out), 64'h80);
      @(negedge clk_in); #1;
      chk("fwd_taken", 64'(l1_valid_out), 64'd0);
      chk("fwd_ready_back", 64'(l1_ready_out), 64'd1);
      repeat (3) @(negedge clk_in);
      chk("fwd_no_l2_read", 64'(rd_issue_seen), 64'(rd0));
      log_q.delete();
      lc_ready_in = 1'b1;
      wait_log(1, "fwd_drain_count");
      lc_ready_in = 1'b0;
      chk_log(0, 1'b1, 22'h80, 64'hDEAD);

      // Miss: the read goes to L2 ahead of the write still queued behind the
      // head (the head is already on the bus and must complete first).
      l1_ready_in = 1'b0;
      req(1'b1, 22'hB0, 64'h11);
      req(1'b1, 22'hB8, 64'h22);
      log_q.delete();
      req(1'b0, 22'hC0, 64'h0);
      #1;
      chk("miss_no_fwd", 64'(l1_valid_out), 64'd0);
      chk("miss_busy_blocks", 64'(l1_ready_out), 64'd0);
      lc_ready_in = 1'b1;
      t = 0;
      while (!lc_ready_out && t < 50) begin
         @(negedge clk_in); #1;
         t++;
      end
      chk("miss_wait_rd", 64'(lc_ready_out), 64'd1);
      lc_valid_in = 1'b1; lc_addr_in = 22'hC0; lc_value_in = 64'h1234;
      @(negedge clk_in);
      lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("miss_hold%0d_valid", c), 64'(l1_valid_out), 64'd1);
         chk($sformatf("miss_hold%0d_addr", c), 64'(l1_addr_out), 64'hC0);
         chk($sformatf("miss_hold%0d_value", c), l1_value_out, 64'h1234);
         chk($sformatf("miss_hold%0d_ready", c), 64'(l1_ready_out), 64'd0);
         @(negedge clk_in); #1;
      end
      l1_ready_in = 1'b1;
      @(negedge clk_in); #1;
      chk("miss_resp_taken", 64'(l1_valid_out), 64'd0);
      wait_log(3, "miss_l2_count");
      lc_ready_in = 1'b0;
      chk_log(0, 1'b1, 22'hB0, 64'h11);
      chk_log(1, 1'b0, 22'hC0, 64'h0);
      chk_log(2, 1'b1, 22'hB8, 64'h22);

      // Flush: requests blocked, both writes drain, done rises after the last pop.
      req(1'b1, 22'h200, 64'h5);
      req(1'b1, 22'h208, 64'h6);
      flush_in = 1'b1;
      #1;
      chk("flush_blocks_req", 64'(l1_ready_out), 64'd0);
      chk("flush_done_while_full", 64'(flush_done_out), 64'd0);
      log_q.delete();
      lc_ready_in = 1'b1;
      found = 1'b0;
      t = 0;
      while (!found && t < 100) begin
         @(negedge clk_in); #1;
         t++;
         if (lc_valid_out && lc_ready_in && lc_we_out && lc_addr_out == 22'h208) begin
            found = 1'b1;
            chk("flush_done_before_last_pop", 64'(flush_done_out), 64'd0);
            @(negedge clk_in); #1;
            chk("flush_done_after_last_pop", 64'(flush_done_out), 64'd1);
         end
      end
      chk("flush_last_pop_seen", 64'(found), 64'd1);
      wait_log(2, "flush_l2_count");
      chk_log(0, 1'b1, 22'h200, 64'h5);
      chk_log(1, 1'b1, 22'h208, 64'h6);
      flush_in = 1'b0;
      #1;
      chk("flush_release_ready", 64'(l1_ready_out), 64'd1);
      chk("flush_release_done", 64'(flush_done_out), 64'd0);
      lc_ready_in = 1'b0;

      // Reset while a write is on the L2 bus.
      req(1'b1, 22'h100, 64'hAA);
      @(negedge clk_in); #1;
      chk("rst_mid_issue_wr", 64'({lc_valid_out, lc_we_out, lc_addr_out}), 64'({1'b1, 1'b1, 22'h100}));
      rst_N_in = 1'b0;
      #1;
      chk("rst_mid_ctrl_outs", 64'({l1_ready_out, l1_valid_out, lc_valid_out, lc_we_out, lc_ready_out, flush_done_out}), 64'd0);
      chk("rst_mid_lc_data", 64'(lc_addr_out) | lc_value_out, 64'd0);
      chk("rst_mid_count", 64'(dut.count_q), 64'd0);
      @(negedge clk_in);
      rst_N_in = 1'b1;
      lc_ready_in = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_in); #1;
         seen = seen | lc_valid_out;
      end
      chk("rst_mid_no_l2_after", 64'(seen), 64'd0);
      chk("rst_mid_ready_after", 64'(l1_ready_out), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
